alu: RTL and testbench
======================

Name: alu

Overview:
- Execute-stage ALU driven directly by the multi-cycle controller's `alu_en`, `alu_op` and `op2_dir` outputs.
- Its registered result feeds the register-file write port when the controller selects the ALU path (`reg_in_dir`=0).
- Single-cycle ops: ADD/ADDI/SUB/SLL/SRL/AND/OR/NOT/XOR/LUI.
- Multi-cycle ops: iterative MUL and signed DIV. For these the controller waits on `busy`/`done` before the write-back state.

Parameters:
- XLEN, 32, datapath width.
- ITER, 32, iterations for MUL/DIV; must equal XLEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_en  in  1  start request; sampled only in IDLE.
- alu_op  in  8  opcode, OP_* encoding.
- op2_dir  in  2  operand-2 select: 00 = rs2_data, 01 = U-imm {instr[31:12],12'b0}, 10 = I-imm sign-extended instr[31:20], 11 = 0.
- instr  in  32  current IR contents, used for immediate decode.
- rs1_data  in  32  register file read port 1 (operand 1).
- rs2_data  in  32  register file read port 2.
- result  out  32  registered result; holds until the next completion.
- busy  out  1  high from the start edge until the result is registered.
- done  out  1  one-cycle pulse when `result` is newly valid.

Behaviour:
- Reset (async, `rst_n`=0): state=IDLE, result=0, busy=0, done=0, counter=0. Reset mid-MUL/DIV aborts the operation; no done pulse is produced.
- States: IDLE, RUN, FIN.
- IDLE, `alu_en`=1 at edge E0:
  - Latch op1=rs1_data, op2 per op2_dir, and the opcode.
  - Single-cycle op: compute and register result at E0, go to FIN. done=1 and busy=0 during the cycle after E0 (latency 1).
  - MUL/DIV: go to RUN with counter=ITER-1, busy=1.
- RUN: one iteration per edge, E1..E32. At E32 register result, go to FIN. done=1 and busy=0 in the following cycle (latency 33).
- FIN: done=1 for exactly one cycle, then IDLE.
  - alu_en sampled in FIN is ignored.
  - A new start is accepted from IDLE only, so back-to-back single-cycle ops complete every 2 cycles.
- alu_en while busy is ignored. Input changes after E0 do not affect the running operation.
- Arithmetic (all modulo 2^32):
  - ADD/ADDI: op1+op2.
  - SUB: op1-op2.
  - SLL: op1<<op2[4:0]. SRL: logical right shift by op2[4:0].
  - AND/OR/XOR: bitwise. NOT: ~op1 (op2 ignored). LUI: op2.
  - MUL: low 32 bits of op1*op2 via shift-add.
  - DIV: signed quotient, truncated toward zero, restoring algorithm on magnitudes with the sign fixed in the final step.
- DIV corner cases:
  - Divisor 0 → result 0xFFFF_FFFF, still 33-cycle latency.
  - 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000.
- Undefined alu_op: single-cycle, result=0, done pulses normally.
- Overflow and carry are not reported.

Decomposition:
- Shared package `cpu_pkg`:
  - OP_* opcode localparams (ADD=0, ADDI=1, SUB=2, MUL=3, DIV=4, SLL=5, SRL=6, AND=7, OR=8, NOT=9, XOR=10, LUI=11).
  - OP2_RS2/OP2_UIMM/OP2_IIMM/OP2_ZERO encodings.
  - The controller imports the same package.
- One sub-module, `alu_muldiv`: iterative multiplier/divider with start/busy/done handshake, counter and sign handling. The top holds the single-cycle datapath, operand mux, immediate decode and the IDLE/RUN/FIN FSM.

Test Plan:
- Reset with rst_n=0 mid-run, then release → result=0, busy=0, done=0; no stale done pulse.
- ADD rs1=5, rs2=7, op2_dir=00; ADDI rs1=5, instr[31:20]=0xFFF, op2_dir=10 → result=12 then 4; each done one cycle after start; busy never high in the done cycle.
- SUB 3-5 → 0xFFFF_FFFE; SLL 1 by op2=0x21 → 2 (only 5 bits used); SRL 0x8000_0000 by 31 → 1; NOT 0 → 0xFFFF_FFFF; LUI instr[31:12]=0x12345, op2_dir=01 → 0x1234_5000.
- MUL 0xFFFF_FFFF*3 → 0xFFFF_FFFD with done exactly 33 cycles after start; toggling alu_en and rs1 mid-run does not change the result or restart.
- DIV -7/2 → 0xFFFF_FFFD; 7/0 → 0xFFFF_FFFF; 0x8000_0000/-1 → 0x8000_0000; each with 33-cycle latency.
- Undefined alu_op=0xFF → result=0 with a single done pulse; then ADD 1+1 issued immediately after → accepted from IDLE, result=2.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode and operand-select encodings for the controller and the execute-stage ALU.
package cpu_pkg;

    localparam logic [7:0] OP_ADD  = 8'd0;
    localparam logic [7:0] OP_ADDI = 8'd1;
    localparam logic [7:0] OP_SUB  = 8'd2;
    localparam logic [7:0] OP_MUL  = 8'd3;
    localparam logic [7:0] OP_DIV  = 8'd4;
    localparam logic [7:0] OP_SLL  = 8'd5;
    localparam logic [7:0] OP_SRL  = 8'd6;
    localparam logic [7:0] OP_AND  = 8'd7;
    localparam logic [7:0] OP_OR   = 8'd8;
    localparam logic [7:0] OP_NOT  = 8'd9;
    localparam logic [7:0] OP_XOR  = 8'd10;
    localparam logic [7:0] OP_LUI  = 8'd11;

    localparam logic [1:0] OP2_RS2  = 2'b00;
    localparam logic [1:0] OP2_UIMM = 2'b01;
    localparam logic [1:0] OP2_IIMM = 2'b10;
    localparam logic [1:0] OP2_ZERO = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } alu_state_e;

    function automatic logic is_muldiv(input logic [7:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic [31:0] op2_sel(input logic [1:0]  dir,
                                            input logic [31:12] instr_hi,
                                            input logic [31:0] rs2);
        logic [31:0] v;
        case (dir)
            OP2_RS2:  v = rs2;
            OP2_UIMM: v = {instr_hi, 12'b0};
            OP2_IIMM: v = {{20{instr_hi[31]}}, instr_hi[31:20]};
            default:  v = 32'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative shift-add multiplier and restoring signed divider; one iteration per clock.
module alu_muldiv import cpu_pkg::*; #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_div,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(ITER);

    logic            busy_q, busy_d;
    logic            div_q, div_d;
    logic            neg_q, neg_d;
    logic            dz_q, dz_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] mq_q, mq_d;
    logic [XLEN-1:0] b_q, b_d;

    logic [XLEN-1:0] mul_acc;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   trial;
    logic            div_ok;
    logic [XLEN-1:0] quo_step;

    always_comb begin
        busy_d = busy_q;
        div_d  = div_q;
        neg_d  = neg_q;
        dz_d   = dz_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        mq_d   = mq_q;
        b_d    = b_q;

        mul_acc  = rem_q + (mq_q[0] ? b_q : '0);
        rem_sh   = {rem_q, mq_q[XLEN-1]};
        trial    = rem_sh - {1'b0, b_q};
        div_ok   = ~trial[XLEN];
        quo_step = {mq_q[XLEN-2:0], div_ok};

        if (start) begin
            busy_d = 1'b1;
            div_d  = is_div;
            cnt_d  = CW'(ITER - 1);
            rem_d  = '0;
            if (is_div) begin
                // Divide magnitudes; the quotient sign is applied on the way out.
                mq_d = op_a[XLEN-1] ? -op_a : op_a;
                b_d  = op_b[XLEN-1] ? -op_b : op_b;
                neg_d = op_a[XLEN-1] ^ op_b[XLEN-1];
                dz_d  = (op_b == '0);
            end else begin
                mq_d  = op_b;
                b_d   = op_a;
                neg_d = 1'b0;
                dz_d  = 1'b0;
            end
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            if (div_q) begin
                rem_d = div_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
                mq_d  = quo_step;
            end else begin
                rem_d = mul_acc;
                mq_d  = mq_q >> 1;
                b_d   = b_q << 1;
            end
        end

        // Final value is presented during the last iteration so the top can register it on that edge.
        done = busy_q && (cnt_q == '0);
        if (div_q)
            result = dz_q ? '1 : (neg_q ? -quo_step : quo_step);
        else
            result = mul_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            dz_q   <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            mq_q   <= '0;
            b_q    <= '0;
        end else begin
            busy_q <= busy_d;
            div_q  <= div_d;
            neg_q  <= neg_d;
            dz_q   <= dz_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            mq_q   <= mq_d;
            b_q    <= b_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: operand select, single-cycle datapath and the IDLE/RUN/FIN sequencer
// around the iterative multiply/divide unit.
module alu import cpu_pkg::*; #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_en,
    input  logic [7:0]      alu_op,
    input  logic [1:0]      op2_dir,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done
);

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            done_q, done_d;

    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] alu_single;
    logic            md_start;
    logic            md_busy;
    logic            md_done;
    logic [XLEN-1:0] md_result;
    logic            unused_instr;

    assign unused_instr = ^instr[11:0];
    assign op1 = rs1_data;
    assign op2 = op2_sel(op2_dir, instr[31:12], rs2_data);

    always_comb begin
        alu_single = '0;
        case (alu_op)
            OP_ADD, OP_ADDI: alu_single = op1 + op2;
            OP_SUB:          alu_single = op1 - op2;
            OP_SLL:          alu_single = op1 << op2[4:0];
            OP_SRL:          alu_single = op1 >> op2[4:0];
            OP_AND:          alu_single = op1 & op2;
            OP_OR:           alu_single = op1 | op2;
            OP_NOT:          alu_single = ~op1;
            OP_XOR:          alu_single = op1 ^ op2;
            OP_LUI:          alu_single = op2;
            default:         alu_single = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        done_d   = 1'b0;
        md_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (alu_en) begin
                    if (is_muldiv(alu_op)) begin
                        md_start = 1'b1;
                        state_d  = ST_RUN;
                    end else begin
                        result_d = alu_single;
                        done_d   = 1'b1;
                        state_d  = ST_FIN;
                    end
                end
            end
            ST_RUN: begin
                if (md_done) begin
                    result_d = md_result;
                    done_d   = 1'b1;
                    state_d  = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    alu_muldiv #(
        .XLEN(XLEN),
        .ITER(ITER)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (alu_op == OP_DIV),
        .op_a   (op1),
        .op_b   (op2),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    assign result = result_q;
    assign busy   = md_busy;
    assign done   = done_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: vector table plus hand sequences, scored through a result queue.
module tb_alu;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_en;
    logic [7:0]  alu_op;
    logic [1:0]  op2_dir;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] result;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    alu #(.XLEN(32), .ITER(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .alu_en   (alu_en),
        .alu_op   (alu_op),
        .op2_dir  (op2_dir),
        .instr    (instr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .result   (result),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        logic [7:0]  op;
        logic [1:0]  dir;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        int          lat;
        int          e0;
        string       name;
    } sb_t;

    sb_t  sb[$];
    sb_t  mon_item;
    vec_t vecs[$];
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: cycle stamp, then sample 1 time unit after the rising edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL stray_done: done=1 with result 0x%08h, expected no done pulse", result);
            end else begin
                mon_item = sb.pop_front();
                chk({mon_item.name, "_result"}, result, mon_item.exp);
                chk({mon_item.name, "_latency"}, cyc - mon_item.e0 + 1, mon_item.lat);
                chk({mon_item.name, "_busy_in_done"}, {31'b0, busy}, 32'd0);
            end
        end
    end

    task automatic issue(input vec_t v);
        @(negedge clk);
        alu_op   = v.op;
        op2_dir  = v.dir;
        instr    = v.instr;
        rs1_data = v.rs1;
        rs2_data = v.rs2;
        alu_en   = 1'b1;
        sb.push_back('{v.exp, v.lat, cyc + 1, v.name});
        @(negedge clk);
        alu_en = 1'b0;
    endtask

    // Wait for all outstanding results, then step past FIN so the next start lands in IDLE.
    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 60) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (sb.size() != 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        alu_en   = 1'b0;
        alu_op   = 8'd0;
        op2_dir  = 2'b00;
        instr    = 32'd0;
        rs1_data = 32'd0;
        rs2_data = 32'd0;

        repeat (2) @(posedge clk);
        #2;
        chk("reset_result", result, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back('{OP_ADD,  OP2_RS2,  32'h0,         32'd5,         32'd7,         32'd12,        1,  "add"});
        vecs.push_back('{OP_ADDI, OP2_IIMM, 32'hFFF0_0000, 32'd5,         32'd99,        32'd4,         1,  "addi"});
        vecs.push_back('{OP_SUB,  OP2_RS2,  32'h0,         32'd3,         32'd5,         32'hFFFF_FFFE, 1,  "sub"});
        vecs.push_back('{OP_SLL,  OP2_RS2,  32'h0,         32'd1,         32'h21,        32'd2,         1,  "sll"});
        vecs.push_back('{OP_SRL,  OP2_RS2,  32'h0,         32'h8000_0000, 32'd31,        32'd1,         1,  "srl"});
        vecs.push_back('{OP_NOT,  OP2_RS2,  32'h0,         32'h0,         32'h1234,      32'hFFFF_FFFF, 1,  "not"});
        vecs.push_back('{OP_LUI,  OP2_UIMM, 32'h1234_50B7, 32'hDEAD,      32'h55,        32'h1234_5000, 1,  "lui"});
        vecs.push_back('{OP_AND,  OP2_RS2,  32'h0,         32'hF0F0,      32'hFF00,      32'hF000,      1,  "and"});
        vecs.push_back('{OP_OR,   OP2_RS2,  32'h0,         32'hF0F0,      32'hFF00,      32'hFFF0,      1,  "or"});
        vecs.push_back('{OP_XOR,  OP2_RS2,  32'h0,         32'hF0F0,      32'hFF00,      32'h0FF0,      1,  "xor"});
        vecs.push_back('{OP_ADD,  OP2_ZERO, 32'hFFFF_FFFF, 32'd9,         32'd5,         32'd9,         1,  "add_zero"});
        vecs.push_back('{OP_MUL,  OP2_RS2,  32'h0,         32'd12345,     32'd678,       32'd8369910,   33, "mul"});
        vecs.push_back('{OP_DIV,  OP2_RS2,  32'h0,         32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div_neg7_2"});
        vecs.push_back('{OP_DIV,  OP2_RS2,  32'h0,         32'd7,         32'd0,         32'hFFFF_FFFF, 33, "div_by0"});
        vecs.push_back('{OP_DIV,  OP2_RS2,  32'h0,         32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "div_ovf"});
        vecs.push_back('{OP_DIV,  OP2_RS2,  32'h0,         32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, "div_100_neg7"});
        vecs.push_back('{OP_DIV,  OP2_RS2,  32'h0,         32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        33, "div_neg100_neg7"});

        foreach (vecs[i]) begin
            issue(vecs[i]);
            wait_drain();
        end

        // MUL with alu_en and rs1 disturbed mid-run: no restart, original operands kept.
        @(negedge clk);
        alu_op   = OP_MUL;
        op2_dir  = OP2_RS2;
        rs1_data = 32'hFFFF_FFFF;
        rs2_data = 32'd3;
        alu_en   = 1'b1;
        sb.push_back('{32'hFFFF_FFFD, 33, cyc + 1, "mul_disturbed"});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            alu_en   = i[0];
            rs1_data = $urandom;
        end
        alu_en = 1'b0;
        chk("mul_busy_midrun", {31'b0, busy}, 32'd1);
        wait_drain();

        // Undefined opcode, then ADD held across FIN: only the IDLE edge may accept it.
        @(negedge clk);
        alu_op   = 8'hFF;
        rs1_data = 32'd77;
        rs2_data = 32'd88;
        alu_en   = 1'b1;
        sb.push_back('{32'd0, 1, cyc + 1, "undef"});
        @(negedge clk);
        alu_op   = OP_ADD;
        op2_dir  = OP2_RS2;
        rs1_data = 32'd1;
        rs2_data = 32'd1;
        @(negedge clk);
        sb.push_back('{32'd2, 1, cyc + 1, "add_after_undef"});
        @(negedge clk);
        alu_en = 1'b0;
        wait_drain();

        // Reset in the middle of a DIV: aborted, no done pulse afterwards.
        @(negedge clk);
        alu_op   = OP_DIV;
        rs1_data = 32'd1000;
        rs2_data = 32'd10;
        alu_en   = 1'b1;
        @(negedge clk);
        alu_en = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_result", result, 32'd0);
        chk("midrun_reset_busy", {31'b0, busy}, 32'd0);
        chk("midrun_reset_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        chk("post_reset_result", result, 32'd0);
        chk("post_reset_busy", {31'b0, busy}, 32'd0);

        issue('{OP_ADD, OP2_RS2, 32'h0, 32'd1, 32'd1, 32'd2, 1, "add_after_reset"});
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
